// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared 7-segment definitions: active-low glyph table
//                (bit0=a .. bit6=g, 0=lit), blank pattern and scan FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Active-low glyphs for hex digits 0-9, A, b, C, d, E, F
    localparam logic [6:0] SEG7_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    // All segments dark
    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    // Per-window scan state
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,   // no valid select window
        ST_SETTLE   = 2'd1,   // window valid, waiting for stability
        ST_CAPTURED = 2'd2    // digit taken, hold until the bus changes
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pattern_decode
//  Description : Combinational active-low segment pattern -> {err, nibble}.
//                Optional macro SEG7_DEC_BLANK_EN: treat 7'h7F as a legal
//                blank that decodes to nibble 0 without error.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       err
);

    // Reverse table lookup; anything not in the table is flagged
    always_comb begin
        nibble = 4'h0;
        err    = 1'b1;
        for (int g = 0; g < 16; g++) begin
            if (pattern == SEG7_GLYPH[g]) begin
                nibble = 4'(g);
                err    = 1'b0;
            end
        end
`ifdef SEG7_DEC_BLANK_EN
        if (pattern == SEG7_BLANK) begin
            nibble = 4'h0;
            err    = 1'b0;
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_decoder
//  Description : Monitors a multiplexed active-low 7-segment bus, captures
//                each digit once stable, decodes it and delivers complete
//                NUM_DIGITS frames over a valid/ready handshake.
//                Optional macro SEG7_DEC_BLANK_EN (see seg7_pattern_decode).
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic [6:0]              Seg_in,
    input  logic [NUM_DIGITS-1:0]   Dig_sel_n,
    output logic                    Frame_valid,
    input  logic                    Frame_ready,
    output logic [4*NUM_DIGITS-1:0] Frame_data,
    output logic [NUM_DIGITS-1:0]   Frame_err,
    output logic                    Overrun
);

    localparam int                    CNT_W      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_MAX    = {CNT_W{1'b1}};
    // Counter value on the cycle where S has been stable STABLE_CYCLES cycles
    localparam logic [CNT_W-1:0]      CAPTURE_AT = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE    = NUM_DIGITS'(1);

    logic [6:0]              seg_meta, seg_s, seg_prev;
    logic [NUM_DIGITS-1:0]   sel_meta, sel_s, sel_prev;
    logic [NUM_DIGITS-1:0]   sel_low;
    logic                    win_valid, same;
    logic [CNT_W-1:0]        stab_cnt;
    scan_state_t             state, state_next;
    logic                    capture;
    logic [3:0]              dec_nibble;
    logic                    dec_err;
    logic [4*NUM_DIGITS-1:0] work_data, work_data_next;
    logic [NUM_DIGITS-1:0]   work_err, work_err_next;
    logic [NUM_DIGITS-1:0]   mask, mask_next;
    logic                    frame_done, out_free;

    // Two-flop synchroniser for the asynchronous bus, plus previous-sample copy
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            seg_meta <= '0;
            seg_s    <= '0;
            seg_prev <= '0;
            sel_meta <= '0;
            sel_s    <= '0;
            sel_prev <= '0;
        end else begin
            seg_meta <= Seg_in;
            seg_s    <= seg_meta;
            seg_prev <= seg_s;
            sel_meta <= Dig_sel_n;
            sel_s    <= sel_meta;
            sel_prev <= sel_s;
        end
    end

    // Window is valid only when exactly one select line is low
    always_comb begin
        sel_low   = ~sel_s;
        win_valid = (sel_low != '0) && ((sel_low & (sel_low - SEL_ONE)) == '0);
        same      = (seg_s == seg_prev) && (sel_s == sel_prev);
    end

    // Saturating count of consecutive unchanged samples inside a window
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stab_cnt <= '0;
        end else if (!win_valid || !same) begin
            stab_cnt <= '0;
        end else if (stab_cnt != CNT_MAX) begin
            stab_cnt <= stab_cnt + 1'b1;
        end
    end

    // Scan FSM state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Scan FSM next state; a single capture per window, re-armed by any change
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        if (!win_valid) begin
            state_next = ST_IDLE;
        end else if (!same) begin
            state_next = ST_SETTLE;
        end else begin
            case (state)
                ST_SETTLE: begin
                    if (stab_cnt == CAPTURE_AT) begin
                        capture    = 1'b1;
                        state_next = ST_CAPTURED;
                    end
                end
                default: ;
            endcase
        end
    end

    seg7_pattern_decode u_decode (
        .pattern (seg_s),
        .nibble  (dec_nibble),
        .err     (dec_err)
    );

    // Working slot update for the selected digit; latest capture wins
    always_comb begin
        work_data_next = work_data;
        work_err_next  = work_err;
        mask_next      = mask;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture && !sel_s[i]) begin
                work_data_next[4*i +: 4] = dec_nibble;
                work_err_next[i]         = dec_err;
                mask_next[i]             = 1'b1;
            end
        end
        frame_done = &mask_next;
        out_free   = !Frame_valid || Frame_ready;
    end

    // Working slots and mask; mask restarts on frame completion
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            work_data <= '0;
            work_err  <= '0;
            mask      <= '0;
        end else begin
            work_data <= work_data_next;
            work_err  <= work_err_next;
            mask      <= frame_done ? '0 : mask_next;
        end
    end

    // Output buffer: load when free, otherwise drop and flag overrun
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Frame_valid <= 1'b0;
            Frame_data  <= '0;
            Frame_err   <= '0;
            Overrun     <= 1'b0;
        end else begin
            Overrun <= frame_done && !out_free;
            if (frame_done && out_free) begin
                Frame_valid <= 1'b1;
                Frame_data  <= work_data_next;
                Frame_err   <= work_err_next;
            end else if (Frame_valid && Frame_ready) begin
                Frame_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
